// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the accumulator-side ALU.
// Pure declarations: no logic, no latency.
// No flow control of its own; users implement the start/busy/done handshake.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_MUL   = 4'd8,
        OP_DIV   = 4'd9,
        OP_MOD   = 4'd10,
        OP_PASSB = 4'd11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    // Opcodes that go through the iterative core (divide-by-zero excepted).
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one step counter.
// One bit per i_step edge; WIDTH steps give the full product/quotient/remainder.
// No backpressure: the owner drives i_load/i_step and decides when to sample.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [CW-1:0]        o_count,
    output logic [2*WIDTH-1:0]   o_product,
    output logic [WIDTH-1:0]     o_quotient,
    output logic [WIDTH-1:0]     o_remainder
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic [CW-1:0]      r_count;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quot_nxt;

    // Both datapaths advance every step; the owner picks the one matching its opcode.
    always_comb begin
        w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_shift    = {r_rem, r_quot[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_divisor};
        // Partial remainder is always below the divisor, so a clear MSB means no borrow.
        w_ge       = ~w_diff[WIDTH];
        w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};
    end

    // Outputs show the post-step values so the final step can be captured at its own edge.
    assign o_product   = w_acc_nxt;
    assign o_quotient  = w_quot_nxt;
    assign o_remainder = w_rem_nxt;
    assign o_count     = r_count;

    // Operand shift registers: load on i_load, one iteration per i_step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, i_a};
            r_mplier  <= i_b;
            r_quot    <= i_a;
            r_rem     <= '0;
            r_divisor <= i_b;
            r_count   <= '0;
        end else if (i_step) begin
            r_acc     <= w_acc_nxt;
            r_mcand   <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier  <= {1'b0, r_mplier[WIDTH-1:1]};
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_count   <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Accumulator-side ALU: single-cycle logic/arith ops plus iterative MUL/DIV/MOD.
// Latency 1 cycle (start -> done) for single-cycle ops and div-by-zero, WIDTH+1 for MUL/DIV/MOD.
// start is ignored while busy; a start in the done cycle is accepted back-to-back.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             vf,
    output logic             busy,
    output logic             done,
    output logic             div_err
);

    localparam int CW = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_zf, r_nf, r_cf, r_vf;
    logic               r_done;
    logic               r_div_err;

    logic               w_accept;
    logic               w_div0;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_cf, w_sc_vf;
    logic [WIDTH-1:0]   w_mc_res;
    logic               w_mc_cf;

    logic               w_fin;
    logic [WIDTH-1:0]   w_fin_res;
    logic               w_fin_cf, w_fin_vf;

    logic [CW-1:0]      w_count;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quotient;
    logic [WIDTH-1:0]   w_remainder;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_div0   = ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
    assign w_load   = w_accept && is_iter_op(op) && !w_div0;
    assign w_step   = (r_state == ST_ITER);
    assign w_last   = (w_count == CW'(WIDTH - 1));

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_a         (a),
        .i_b         (b),
        .o_count     (w_count),
        .o_product   (w_product),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder)
    );

    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};
    // Extra bit catches the last bit shifted out; a zero shift leaves it 0.
    assign w_shl = {1'b0, a} << b[3:0];
    assign w_shr = {a, 1'b0} >> b[3:0];

    // Single-cycle results and flags from the live inputs (also covers div-by-zero).
    always_comb begin
        w_sc_res = a;
        w_sc_cf  = 1'b0;
        w_sc_vf  = 1'b0;
        case (op)
            OP_ADD: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_cf  = w_sum[WIDTH];
                w_sc_vf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_dif[WIDTH-1:0];
                w_sc_cf  = w_dif[WIDTH];
                w_sc_vf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   w_sc_res = a & b;
            OP_OR:    w_sc_res = a | b;
            OP_XOR:   w_sc_res = a ^ b;
            OP_NOT:   w_sc_res = ~a;
            OP_SHL: begin
                w_sc_res = w_shl[WIDTH-1:0];
                w_sc_cf  = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_sc_res = w_shr[WIDTH:1];
                w_sc_cf  = w_shr[0];
            end
            OP_DIV:   w_sc_res = '1;
            OP_MOD:   w_sc_res = a;
            OP_PASSB: w_sc_res = b;
            default:  w_sc_res = a;
        endcase
    end

    // Final iterative result selected by the captured opcode.
    always_comb begin
        w_mc_res = w_product[WIDTH-1:0];
        w_mc_cf  = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_mc_res = w_product[WIDTH-1:0];
                w_mc_cf  = |w_product[2*WIDTH-1:WIDTH];
            end
            OP_DIV:  w_mc_res = w_quotient;
            OP_MOD:  w_mc_res = w_remainder;
            default: w_mc_res = w_product[WIDTH-1:0];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state plus the completion strobe and the values to publish with it.
    always_comb begin
        w_state_nxt = r_state;
        w_fin       = 1'b0;
        w_fin_res   = w_sc_res;
        w_fin_cf    = w_sc_cf;
        w_fin_vf    = w_sc_vf;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_ITER;
                end else if (w_accept) begin
                    w_fin = 1'b1;
                end
            end
            ST_ITER: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_fin       = 1'b1;
                    w_fin_res   = w_mc_res;
                    w_fin_cf    = w_mc_cf;
                    w_fin_vf    = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Captured opcode for the iterative path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_op <= '0;
        else if (w_load) r_op <= op;
    end

    // Result/flag registers: written only on completion; done is a single pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_cf     <= 1'b0;
            r_vf     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_result <= w_fin_res;
                r_zf     <= (w_fin_res == '0);
                r_nf     <= w_fin_res[WIDTH-1];
                r_cf     <= w_fin_cf;
                r_vf     <= w_fin_vf;
            end
        end
    end

    // div_err follows each accepted start: set for a zero divisor, cleared otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_div_err <= 1'b0;
        else if (w_accept) r_div_err <= w_div0;
    end

    assign result  = r_result;
    assign zf      = r_zf;
    assign nf      = r_nf;
    assign cf      = r_cf;
    assign vf      = r_vf;
    assign busy    = (r_state == ST_ITER);
    assign done    = r_done;
    assign div_err = r_div_err;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: issued ops push reference results, a monitor pops on done.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic [15:0] result;
    logic        zf, nf, cf, vf, busy, done, div_err;

    alu_unit #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (result),
        .zf      (zf),
        .nf      (nf),
        .cf      (cf),
        .vf      (vf),
        .busy    (busy),
        .done    (done),
        .div_err (div_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        bit          zf, nf, cf, vf, de;
        int          due;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int to_signed16(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    // Reference behaviour from plain integer arithmetic; due holds the latency in cycles.
    function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t            e;
        int unsigned     ux;
        int unsigned     uy;
        int              ss;
        int unsigned     n;
        longint unsigned p;
        ux = x;
        uy = y;
        e.op = o;
        e.res = x;
        e.cf = 0;
        e.vf = 0;
        e.de = 0;
        e.due = 1;
        n = uy % 16;
        case (o)
            4'd0: begin
                e.res = 16'(ux + uy);
                e.cf  = (ux + uy) > 65535;
                ss    = to_signed16(ux) + to_signed16(uy);
                e.vf  = (ss > 32767) || (ss < -32768);
            end
            4'd1: begin
                e.res = 16'(ux - uy);
                e.cf  = ux < uy;
                ss    = to_signed16(ux) - to_signed16(uy);
                e.vf  = (ss > 32767) || (ss < -32768);
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = ~x;
            4'd6: begin
                e.res = 16'(ux << n);
                e.cf  = (n != 0) && (((ux >> (16 - n)) & 1) == 1);
            end
            4'd7: begin
                e.res = 16'(ux >> n);
                e.cf  = (n != 0) && (((ux >> (n - 1)) & 1) == 1);
            end
            4'd8: begin
                p     = longint'(ux) * longint'(uy);
                e.res = 16'(p);
                e.cf  = p >= 65536;
                e.due = 17;
            end
            4'd9: begin
                if (uy == 0) begin
                    e.res = 16'hFFFF;
                    e.de  = 1;
                end else begin
                    e.res = 16'(ux / uy);
                    e.due = 17;
                end
            end
            4'd10: begin
                if (uy == 0) begin
                    e.res = x;
                    e.de  = 1;
                end else begin
                    e.res = 16'(ux % uy);
                    e.due = 17;
                end
            end
            4'd11: e.res = y;
            default: e.res = x;
        endcase
        e.zf = (e.res == 16'd0);
        e.nf = e.res[15];
        return e;
    endfunction

    // Monitor: every done pops one expectation; result must hold between dones.
    logic [15:0] held = 16'd0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 16'd0;
            end else if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("op%0d result", e.op), result, e.res);
                    check($sformatf("op%0d zf", e.op), zf, e.zf);
                    check($sformatf("op%0d nf", e.op), nf, e.nf);
                    check($sformatf("op%0d cf", e.op), cf, e.cf);
                    check($sformatf("op%0d vf", e.op), vf, e.vf);
                    check($sformatf("op%0d div_err", e.op), div_err, e.de);
                    check($sformatf("op%0d done_cycle", e.op), cyc, e.due);
                    check($sformatf("op%0d busy_at_done", e.op), busy, 0);
                end
                held = result;
            end else begin
                check("result_hold", result, held);
            end
        end
    end

    // Waits for busy to drop (pulsing ignored starts with junk inputs), then issues one op.
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   w;
        w = 0;
        while (busy && w < 100) begin
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 100 cycles");
        end
        e = model(o, x, y);
        e.due = cyc + e.due;
        sbq.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    initial begin
        logic [15:0] ry;
        int          w;

        #1;
        check("reset result", result, 0);
        check("reset zf", zf, 0);
        check("reset nf", nf, 0);
        check("reset cf", cf, 0);
        check("reset vf", vf, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_err", div_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Non-zero result first so the mid-MUL reset visibly clears it.
        issue(4'd11, 16'h0000, 16'h1234);
        issue(4'd8, 16'd1234, 16'd77);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset result", result, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        issue(4'd0, 16'h7FFF, 16'h0001);
        issue(4'd1, 16'h0003, 16'h0005);
        issue(4'd6, 16'h8001, 16'h0001);
        issue(4'd8, 16'd300, 16'd300);
        issue(4'd9, 16'd1000, 16'd7);
        issue(4'd10, 16'd1000, 16'd7);
        issue(4'd9, 16'd1234, 16'd0);
        issue(4'd11, 16'd1234, 16'd0);
        issue(4'd10, 16'd55, 16'd0);
        issue(4'd7, 16'h8001, 16'd0);
        issue(4'd7, 16'h8001, 16'd15);
        issue(4'd1, 16'h8000, 16'h0001);
        issue(4'd8, 16'hFFFF, 16'hFFFF);
        issue(4'd9, 16'd5, 16'd9);
        issue(4'd14, 16'hBEEF, 16'h0001);

        repeat (300) begin
            ry = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ry = 16'd0;
            issue(4'($urandom_range(0, 15)), 16'($urandom), ry);
        end

        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 16-bit execution unit directly upstream of the accumulator register; its `result` drives the accumulator's `in`.
- Operand `a` is the current accumulator value; operand `b` comes from the register file or immediate path.
- Single-cycle logic/arithmetic ops complete in one cycle; multiply/divide/modulo run iteratively over 16 cycles.
- Uses a start/busy/done handshake with the controller.

Parameters:
- WIDTH, 16, datapath width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- start  in  1  request; sampled only when busy=0.
- op  in  4  opcode, captured with start.
- a  in  WIDTH  operand A (accumulator value), captured with start.
- b  in  WIDTH  operand B, captured with start.
- result  out  WIDTH  registered result; holds its value until the next done.
- zf, nf, cf, vf  out  1 each  registered flags; update only when done pulses.
- busy  out  1  high while a multi-cycle op iterates.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- div_err  out  1  set with done on a DIV/MOD by zero; cleared on the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - result=0, zf=nf=cf=vf=0, busy=0, done=0, div_err=0, state=IDLE.
  - Any in-progress operation is discarded without a done pulse.
- FSM states and transitions:
  - IDLE: start=1 with a single-cycle op → results registered at that edge, done=1 next cycle, stay in IDLE.
  - IDLE: start=1 with op MUL/DIV/MOD and a legal divisor → load the operand shift registers, count=0, busy=1, go to ITER.
  - ITER: one shift-add (MUL) or restore-subtract (DIV/MOD) step per edge.
  - ITER, count=WIDTH-1 at an edge: write result and flags, done=1, busy=0, return to IDLE.
  - A multi-cycle op started at edge N gives done high in the cycle following edge N+16.
- Handshake:
  - start while busy=1 is ignored.
  - start while done=1 and busy=0 is accepted (back-to-back operation).
  - done never stays high for two consecutive cycles unless a new start was accepted.
  - Input changes after capture have no effect.
- Opcodes:
  - 0 ADD; 1 SUB (a-b); 2 AND; 3 OR; 4 XOR; 5 NOT a.
  - 6 SHL a by b[3:0]; 7 SHR (logical) a by b[3:0].
  - 8 MUL (low WIDTH bits of the product); 9 DIV (unsigned quotient); 10 MOD (unsigned remainder).
  - 11 PASS b.
  - 12-15 reserved: result=a, one-cycle latency.
- Flags, written only with done:
  - zf = (result==0); nf = result[WIDTH-1].
  - cf: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR last bit shifted out, 0 if the shift amount is 0; MUL 1 if the upper product half is non-zero; all other ops 0.
  - vf: ADD/SUB signed overflow; all other ops 0.
- Divide by zero (b=0 with DIV/MOD):
  - No iteration; one-cycle latency.
  - DIV result=all ones; MOD result=a.
  - div_err=1, cf=vf=0, zf/nf computed from the result.
- Arithmetic wrap-around: ADD/SUB wrap modulo 2^WIDTH; the carry/borrow goes to cf only.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD..OP_PASSB.
  - State encoding IDLE/ITER.
  - Default WIDTH.
- Sub-module alu_muldiv: the iterative multiply/restoring-divide core. It has load/step inputs, count, and product/quotient/remainder outputs. The top level owns the FSM, the single-cycle ops, the flags and the handshake.

Test Plan:
- Reset then idle: rst=0 mid-MUL (busy=1) → busy=0, done=0, result=0 immediately. After release, no stale done appears.
- ADD a=16'h7FFF, b=16'h0001 → done one cycle after start, result=16'h8000, vf=1, nf=1, cf=0, zf=0.
- SUB a=16'h0003, b=16'h0005 → result=16'hFFFE, cf=1, vf=0. Then SHL a=16'h8001, b=1 → result=16'h0002, cf=1.
- MUL a=300, b=300 → busy for 16 cycles, done in the 17th cycle after start, result=16'h5F90, cf=1. A start pulsed mid-iteration is ignored.
- DIV a=1000, b=7 → result=142 with 16-cycle latency. Back-to-back MOD 1000,7 started in the done cycle → result=6.
- DIV a=1234, b=0 → one-cycle done, result=16'hFFFF, div_err=1. The next start (PASS b=0) clears div_err and sets zf=1.
